bitrev_frame_ctrl: RTL and testbench

Controller that owns both ports of a single-port-pair block RAM (N words of I+F bits, 1-cycle registered read, read data held when read enable is low). It accepts a stream of N time-domain samples, writes them into the RAM at bit-reversed addresses, then reads the RAM back in natural address order as an output stream. The output stream has valid/ready backpressure, so the FFT input stage receives the frame already in bit-reversed order. It is not double-buffered: one frame is loaded, then drained, then the next frame is loaded.

---
 rtl/bitrev_frame_ctrl_if.sv | 40 ++++
 rtl/bitrev_frame_ctrl.sv | 147 ++++++++++++++
 tb/tb_bitrev_frame_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bitrev_frame_ctrl_if.sv
// Sample-in / RAM / sample-out signal bundle for bitrev_frame_ctrl.
// master: the controller side; slave: the source, the RAM and the sink side.
// No storage; the bundle is wires only, so it adds no latency.
interface bitrev_frame_ctrl_if #(
  parameter int N = 16,
  parameter int I = 8,
  parameter int F = 8
);
  // Input sample stream
  logic                   i_in_valid;
  logic                   o_in_ready;
  logic [I+F-1:0]         i_in_data;
  // RAM write port
  logic                   o_wr_en;
  logic [$clog2(N)-1:0]   o_wr_addr;
  logic [I+F-1:0]         o_wr_data;
  // RAM read port
  logic                   o_rd_en;
  logic [$clog2(N)-1:0]   o_rd_addr;
  logic [I+F-1:0]         i_rd_data;
  // Output sample stream
  logic                   o_out_valid;
  logic                   i_out_ready;
  logic [I+F-1:0]         o_out_data;
  logic                   o_out_last;
  // Status
  logic                   o_busy;

  modport master (
    input  i_in_valid, i_in_data, i_rd_data, i_out_ready,
    output o_in_ready, o_wr_en, o_wr_addr, o_wr_data,
           o_rd_en, o_rd_addr, o_out_valid, o_out_data, o_out_last, o_busy
  );

  modport slave (
    output i_in_valid, i_in_data, i_rd_data, i_out_ready,
    input  o_in_ready, o_wr_en, o_wr_addr, o_wr_data,
           o_rd_en, o_rd_addr, o_out_valid, o_out_data, o_out_last, o_busy
  );
endinterface

// File: rtl/bitrev_frame_ctrl.sv
// Loads one N-sample frame into RAM at bit-reversed addresses, then drains it in natural order.
// Latency: first output 3 cycles after the last write, then 1 sample/cycle while ready.
// Backpressure: 2-entry output FIFO; reads are throttled so nothing is dropped; input stalls in DRAIN.
module bitrev_frame_ctrl #(
  parameter int N = 16,
  parameter int I = 8,
  parameter int F = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bitrev_frame_ctrl_if.master   bus
);
  localparam int W  = I + F;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [AW:0]   RD_TOTAL = (AW + 1)'(N);

  typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [AW:0]     rd_cnt_q, rd_cnt_d;     // one extra bit so "all N issued" is representable
  logic [AW-1:0]   out_cnt_q, out_cnt_d;
  logic            inflight_q, inflight_d;
  logic [W-1:0]    fifo_mem_q [2];
  logic [W-1:0]    fifo_mem_d [2];
  logic            fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic            fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;

  logic            accept;
  logic            issue;
  logic            push;
  logic            pop;
  logic            last_pop;
  logic [2:0]      occ;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
    return r;
  endfunction

  // Output stream is the FIFO head; data words pass through untouched.
  assign bus.o_out_valid = (fifo_cnt_q != 2'd0);
  assign bus.o_out_data  = fifo_mem_q[fifo_rd_ptr_q];
  assign bus.o_out_last  = bus.o_out_valid && (out_cnt_q == LAST_IDX);
  assign bus.o_wr_data   = bus.i_in_data;
  assign bus.o_rd_addr   = rd_cnt_q[AW-1:0];

  assign pop      = bus.o_out_valid && bus.i_out_ready;
  assign last_pop = pop && (out_cnt_q == LAST_IDX);
  assign push     = inflight_q;
  // Entries held plus the read already on its way from the RAM.
  assign occ      = {1'b0, fifo_cnt_q} + {2'b0, inflight_q};

  // FSM next state and handshake/RAM control outputs.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    issue          = 1'b0;
    bus.o_in_ready = 1'b0;
    bus.o_wr_en    = 1'b0;
    bus.o_wr_addr  = '0;
    bus.o_rd_en    = 1'b0;
    bus.o_busy     = 1'b0;
    case (state_q)
      LOAD: begin
        bus.o_in_ready = 1'b1;
        accept         = bus.i_in_valid;
        bus.o_wr_en    = accept;
        bus.o_wr_addr  = accept ? bitrev(wr_cnt_q) : '0;
        if (accept && (wr_cnt_q == LAST_IDX)) state_d = DRAIN;
      end
      DRAIN: begin
        bus.o_busy  = 1'b1;
        // A pop this cycle frees a slot, so a read can still issue with 2 held.
        issue       = (rd_cnt_q < RD_TOTAL) && (occ < ({2'b0, pop} + 3'd2));
        bus.o_rd_en = issue;
        if (last_pop) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Counters and the 2-entry output FIFO.
  always_comb begin
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    out_cnt_d     = out_cnt_q;
    inflight_d    = issue;
    fifo_mem_d    = fifo_mem_q;
    fifo_wr_ptr_d = fifo_wr_ptr_q;
    fifo_rd_ptr_d = fifo_rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

    if (accept) begin
      wr_cnt_d = (wr_cnt_q == LAST_IDX) ? '0 : wr_cnt_q + AW'(1);
    end
    if (issue) rd_cnt_d = rd_cnt_q + (AW + 1)'(1);
    if (push) begin
      fifo_mem_d[fifo_wr_ptr_q] = bus.i_rd_data;
      fifo_wr_ptr_d             = ~fifo_wr_ptr_q;
    end
    if (pop) begin
      fifo_rd_ptr_d = ~fifo_rd_ptr_q;
      out_cnt_d     = out_cnt_q + AW'(1);
    end
    // The final pop leaves nothing held or in flight; restart cleanly for the next frame.
    if (last_pop) begin
      rd_cnt_d      = '0;
      out_cnt_d     = '0;
      inflight_d    = 1'b0;
      fifo_wr_ptr_d = 1'b0;
      fifo_rd_ptr_d = 1'b0;
      fifo_cnt_d    = 2'd0;
    end
  end

  // State registers with synchronous reset; a reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      out_cnt_q     <= '0;
      inflight_q    <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      out_cnt_q     <= out_cnt_d;
      inflight_q    <= inflight_d;
      fifo_mem_q[0] <= fifo_mem_d[0];
      fifo_mem_q[1] <= fifo_mem_d[1];
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end
endmodule

// File: tb/tb_bitrev_frame_ctrl.sv
// Directed bench for bitrev_frame_ctrl at N=8 with a behavioural registered-read RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after it.
// Per-sample expectations come from a hand-filled table of write addresses and output offsets.
module tb_bitrev_frame_ctrl;
  localparam int N  = 8;
  localparam int I  = 8;
  localparam int F  = 8;
  localparam int W  = I + F;
  localparam int AW = 3;

  typedef struct {
    logic [W-1:0]  in_off;   // input sample k is base + in_off
    logic [AW-1:0] wr_addr;  // expected RAM address for input k
    logic [W-1:0]  out_off;  // output k must be base + out_off
  } vec_t;

  vec_t tbl [N];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bitrev_frame_ctrl_if #(.N(N), .I(I), .F(F)) bus ();

  bitrev_frame_ctrl #(.N(N), .I(I), .F(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Block RAM model: registered read, output held while read enable is low.
  logic [W-1:0] ram [N];
  always @(posedge clk) begin
    if (bus.o_wr_en) ram[bus.o_wr_addr] <= bus.o_wr_data;
    if (bus.o_rd_en) bus.i_rd_data <= ram[bus.o_rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Accept N samples base+in_off; optional random idle gaps between them.
  task automatic load_frame(input logic [W-1:0] base, input bit gaps);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < N && cyc < 200) begin
      @(posedge clk); #1;
      bus.i_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_in_data  = bus.i_in_valid ? base + tbl[k].in_off : 16'hBAD0;
      #1;
      if (bus.i_in_valid) begin
        check("ld_ready",   bus.o_in_ready, 1);
        check("ld_busy",    bus.o_busy, 0);
        check("ld_wr_en",   bus.o_wr_en, 1);
        check("ld_wr_addr", bus.o_wr_addr, tbl[k].wr_addr);
        check("ld_wr_data", bus.o_wr_data, base + tbl[k].in_off);
        k++;
      end else begin
        check("ld_idle_wr_en", bus.o_wr_en, 0);
      end
      cyc++;
    end
    if (k < N) check("ld_timeout", k, N);
  endtask

  // Drain starting the cycle after the last write; stops after stop_after pops.
  task automatic drain_frame(input logic [W-1:0] base, input bit rand_rdy,
                             input bit junk, input int stop_after);
    int pops, issued, cyc, first_v, last_pop_cyc, max_occ;
    bit order_ok, prev_stall, prev_last;
    logic [W-1:0] prev_dat;
    pops = 0; issued = 0; cyc = 0; first_v = -1; last_pop_cyc = -1; max_occ = 0;
    order_ok = 1'b1; prev_stall = 1'b0; prev_last = 1'b0; prev_dat = '0;
    while (pops < stop_after && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      bus.i_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_in_valid  = junk;
      bus.i_in_data   = 16'hDEAD ^ 16'(cyc);
      #1;
      if (cyc == 1) begin
        check("dr_busy_rise",  bus.o_busy, 1);
        check("dr_not_ready",  bus.o_in_ready, 0);
        check("dr_first_rd",   bus.o_rd_en, 1);
        check("dr_first_addr", bus.o_rd_addr, 0);
      end
      if (junk) begin
        check("dr_junk_wr_en", bus.o_wr_en, 0);
        check("dr_junk_ready", bus.o_in_ready, 0);
      end
      if (prev_stall) begin
        check("stall_valid", bus.o_out_valid, 1);
        check("stall_data",  bus.o_out_data, prev_dat);
        check("stall_last",  bus.o_out_last, prev_last);
      end
      if (bus.o_rd_en) begin
        if (bus.o_rd_addr != AW'(issued)) order_ok = 1'b0;
        issued++;
      end
      if (bus.o_out_valid && first_v < 0) first_v = cyc;
      if (bus.o_out_valid && bus.i_out_ready) begin
        check("dr_data", bus.o_out_data, base + tbl[pops].out_off);
        check("dr_last", bus.o_out_last, pops == N - 1);
        pops++;
        last_pop_cyc = cyc;
      end
      if (issued - pops > max_occ) max_occ = issued - pops;
      prev_stall = bus.o_out_valid && !bus.i_out_ready;
      prev_dat   = bus.o_out_data;
      prev_last  = bus.o_out_last;
    end
    bus.i_in_valid = 1'b0;
    if (pops < stop_after) check("dr_timeout", pops, stop_after);
    check("dr_occ_le2", max_occ <= 2, 1);
    check("dr_first_valid_cyc", first_v, 3);
    if (stop_after == N) begin
      check("dr_reads",    issued, N);
      check("dr_rd_order", order_ok, 1);
      if (!rand_rdy) check("dr_last_cyc", last_pop_cyc, N + 2);
    end
  endtask

  initial begin
    tbl[0] = '{16'd0, 3'd0, 16'd0};
    tbl[1] = '{16'd1, 3'd4, 16'd4};
    tbl[2] = '{16'd2, 3'd2, 16'd2};
    tbl[3] = '{16'd3, 3'd6, 16'd6};
    tbl[4] = '{16'd4, 3'd1, 16'd1};
    tbl[5] = '{16'd5, 3'd5, 16'd5};
    tbl[6] = '{16'd6, 3'd3, 16'd3};
    tbl[7] = '{16'd7, 3'd7, 16'd7};

    bus.i_in_valid  = 1'b0;
    bus.i_in_data   = '0;
    bus.i_out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready",  bus.o_in_ready, 1);
    check("rst_wr_en",     bus.o_wr_en, 0);
    check("rst_wr_addr",   bus.o_wr_addr, 0);
    check("rst_rd_en",     bus.o_rd_en, 0);
    check("rst_rd_addr",   bus.o_rd_addr, 0);
    check("rst_out_valid", bus.o_out_valid, 0);
    check("rst_out_data",  bus.o_out_data, 0);
    check("rst_out_last",  bus.o_out_last, 0);
    check("rst_busy",      bus.o_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Plain frame 0..7, ready held high.
    load_frame(16'd0, 1'b0);
    drain_frame(16'd0, 1'b0, 1'b0, N);

    // Random backpressure.
    load_frame(16'h3C40, 1'b0);
    drain_frame(16'h3C40, 1'b1, 1'b0, N);

    // Input gaps while loading, junk input during drain.
    load_frame(16'h5A00, 1'b1);
    drain_frame(16'h5A00, 1'b0, 1'b1, N);

    // Reset after the 5th output, then frame 10..17.
    load_frame(16'h2200, 1'b0);
    drain_frame(16'h2200, 1'b0, 1'b0, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.o_out_valid, 0);
    check("mid_rst_in_ready",  bus.o_in_ready, 1);
    check("mid_rst_busy",      bus.o_busy, 0);
    load_frame(16'd10, 1'b0);
    drain_frame(16'd10, 1'b0, 1'b0, N);

    // Back-to-back frames: next load starts the cycle after the last pop.
    load_frame(16'h7100, 1'b0);
    drain_frame(16'h7100, 1'b0, 1'b0, N);
    load_frame(16'h0E20, 1'b0);
    drain_frame(16'h0E20, 1'b1, 1'b0, N);

    @(posedge clk); #2;
    check("end_idle_ready", bus.o_in_ready, 1);
    check("end_idle_valid", bus.o_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
